diferenta_produs_impartire: RTL and testbench

DIFERENTA_PRODUS_IMPARTIRE -- requirements
Module: diferenta_produs_impartire

---
 rtl/diferenta_produs_impartire_if.sv | 31 +++
 rtl/diferenta_produs_impartire.sv | 156 +++++++++++++++
 tb/tb_diferenta_produs_impartire.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/diferenta_produs_impartire_if.sv
// Operand/result bundle for diferenta_produs_impartire: operands plus valid_in in, three result channels out.
// Results are plain valid pulses with no ready; the divider exposes div_busy instead.
interface diferenta_produs_impartire_if #(parameter int WIDTH = 28);
    logic signed [WIDTH-1:0] n1;
    logic signed [WIDTH-1:0] n2;
    logic                    valid_in;
    logic signed [WIDTH-1:0] dif_out;
    logic                    dif_valid;
    logic                    dif_ovf;
    logic signed [WIDTH-1:0] prod_out;
    logic                    prod_valid;
    logic                    prod_ovf;
    logic signed [WIDTH-1:0] div_out;
    logic                    div_valid;
    logic                    div_err;
    logic                    div_busy;

    modport master (
        output n1, n2, valid_in,
        input  dif_out, dif_valid, dif_ovf,
        input  prod_out, prod_valid, prod_ovf,
        input  div_out, div_valid, div_err, div_busy
    );

    modport slave (
        input  n1, n2, valid_in,
        output dif_out, dif_valid, dif_ovf,
        output prod_out, prod_valid, prod_ovf,
        output div_out, div_valid, div_err, div_busy
    );
endinterface

// File: rtl/diferenta_produs_impartire.sv
// Signed difference/product (latency 1, one per cycle) and restoring divider (WIDTH+1 cycles, ignores requests while busy).
// Define OVF_SAT_EN to saturate overflowed difference/product instead of wrapping.
module diferenta_produs_impartire #(
    parameter int WIDTH = 28
) (
    input logic                   clk,
    input logic                   rst,
    diferenta_produs_impartire_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [WIDTH-1:0]   a, b;
    logic [WIDTH-1:0]   dif_raw, dif_res, prod_res;
    logic               dif_ovf_c, prod_ovf_c;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod_full;

    assign a = bus.n1;
    assign b = bus.n2;

    always_comb begin
        dif_raw   = a - b;
        dif_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (dif_raw[WIDTH-1] != a[WIDTH-1]);
        a_ext     = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext     = {{WIDTH{b[WIDTH-1]}}, b};
        // Low 2*WIDTH bits of a sign-extended product are signedness-independent.
        prod_full = a_ext * b_ext;
        prod_ovf_c = (|prod_full[2*WIDTH-1:WIDTH-1]) && !(&prod_full[2*WIDTH-1:WIDTH-1]);
`ifdef OVF_SAT_EN
        dif_res  = dif_ovf_c ? (a[WIDTH-1] ? SMIN : SMAX) : dif_raw;
        prod_res = prod_ovf_c ? (prod_full[2*WIDTH-1] ? SMIN : SMAX) : prod_full[WIDTH-1:0];
`else
        dif_res  = dif_raw;
        prod_res = prod_full[WIDTH-1:0];
`endif
    end

    logic [WIDTH-1:0] dif_q, prod_q;
    logic             dif_vld_q, dif_ovf_q, prod_vld_q, prod_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dif_q      <= '0;
            dif_vld_q  <= 1'b0;
            dif_ovf_q  <= 1'b0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            prod_ovf_q <= 1'b0;
        end else begin
            dif_vld_q  <= bus.valid_in;
            prod_vld_q <= bus.valid_in;
            if (bus.valid_in) begin
                dif_q      <= dif_res;
                dif_ovf_q  <= dif_ovf_c;
                prod_q     <= prod_res;
                prod_ovf_q <= prod_ovf_c;
            end
        end
    end

    // Divider: magnitudes shifted through rem/quo, sign and error applied on the last step.
    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] quo, quo_nxt, rem, rem_nxt, dvs, dvs_nxt;
    logic             neg, neg_nxt, qovf, qovf_nxt;
    logic [WIDTH-1:0] div_q, div_nxt;
    logic             err_q, err_nxt;
    logic [WIDTH:0]   rem_sh, sub;
    logic             ge;
    logic [WIDTH-1:0] quo_step;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        quo_nxt   = quo;
        rem_nxt   = rem;
        dvs_nxt   = dvs;
        neg_nxt   = neg;
        qovf_nxt  = qovf;
        div_nxt   = div_q;
        err_nxt   = err_q;
        rem_sh    = {rem, quo[WIDTH-1]};
        sub       = rem_sh - {1'b0, dvs};
        ge        = ~sub[WIDTH];
        quo_step  = {quo[WIDTH-2:0], ge};
        case (state)
            IDLE: begin
                if (bus.valid_in) begin
                    quo_nxt  = a[WIDTH-1] ? -a : a;
                    dvs_nxt  = b[WIDTH-1] ? -b : b;
                    rem_nxt  = '0;
                    neg_nxt  = a[WIDTH-1] ^ b[WIDTH-1];
                    qovf_nxt = (a == SMIN) && (&b);
                    cnt_nxt  = CW'(WIDTH - 1);
                    if (b == '0) begin
                        state_nxt = DONE;
                        div_nxt   = '0;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                quo_nxt = quo_step;
                rem_nxt = ge ? sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                cnt_nxt = cnt - 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                    div_nxt   = qovf ? SMIN : (neg ? -quo_step : quo_step);
                    err_nxt   = qovf;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg   <= 1'b0;
            qovf  <= 1'b0;
            div_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            quo   <= quo_nxt;
            rem   <= rem_nxt;
            dvs   <= dvs_nxt;
            neg   <= neg_nxt;
            qovf  <= qovf_nxt;
            div_q <= div_nxt;
            err_q <= err_nxt;
        end
    end

    assign bus.dif_out    = dif_q;
    assign bus.dif_valid  = dif_vld_q;
    assign bus.dif_ovf    = dif_ovf_q;
    assign bus.prod_out   = prod_q;
    assign bus.prod_valid = prod_vld_q;
    assign bus.prod_ovf   = prod_ovf_q;
    assign bus.div_out    = div_q;
    assign bus.div_err    = err_q;
    assign bus.div_valid  = (state == DONE);
    assign bus.div_busy   = (state != IDLE);
endmodule

// File: tb/tb_diferenta_produs_impartire.sv
// Bench for diferenta_produs_impartire: directed cases plus random stream against an arithmetic reference model.
module tb_diferenta_produs_impartire;
    localparam int W = 28;
    localparam longint LMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint LMIN = -(longint'(1) << (W - 1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    diferenta_produs_impartire_if #(.WIDTH(W)) bus ();
    diferenta_produs_impartire #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_bad = 0;

    // Expected outputs after the most recent edge.
    logic signed [W-1:0] m_dif, m_prod, m_div, m_pend;
    logic m_dif_vld, m_dif_ovf, m_prod_vld, m_prod_ovf, m_div_vld, m_div_err, m_pend_err;
    bit   m_busy, m_done;
    int   m_left;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic signed [W-1:0] lo(input longint v);
        lo = v[W-1:0];
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic signed [W-1:0] a,
                              input logic signed [W-1:0] b);
        longint la, lb, d, p;
        la = longint'(a);
        lb = longint'(b);
        if (r) begin
            m_dif = '0; m_prod = '0; m_div = '0;
            m_dif_vld = 0; m_dif_ovf = 0; m_prod_vld = 0; m_prod_ovf = 0;
            m_div_vld = 0; m_div_err = 0; m_busy = 0; m_done = 0;
            return;
        end
        m_dif_vld  = v;
        m_prod_vld = v;
        if (v) begin
            d = la - lb;
            p = la * lb;
            m_dif_ovf  = (d > LMAX) || (d < LMIN);
            m_prod_ovf = (p > LMAX) || (p < LMIN);
            m_dif  = lo(d);
            m_prod = lo(p);
`ifdef OVF_SAT_EN
            if (m_dif_ovf)  m_dif  = (d > LMAX) ? lo(LMAX) : lo(LMIN);
            if (m_prod_ovf) m_prod = (p > LMAX) ? lo(LMAX) : lo(LMIN);
`endif
        end
        m_div_vld = 0;
        if (m_busy) begin
            if (m_done) begin
                m_busy = 0;
                m_done = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_div_vld = 1;
                    m_done    = 1;
                    m_div     = m_pend;
                    m_div_err = m_pend_err;
                end
            end
        end else if (v) begin
            m_busy = 1;
            if (lb == 0) begin
                m_done = 1; m_div_vld = 1; m_div = '0; m_div_err = 1;
            end else begin
                m_left = W;
                if (la == LMIN && lb == -1) begin
                    m_pend = lo(LMIN); m_pend_err = 1;
                end else begin
                    m_pend = lo(la / lb); m_pend_err = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("dif_out", bus.dif_out, m_dif);
        chk("dif_valid", bus.dif_valid, m_dif_vld);
        chk("dif_ovf", bus.dif_ovf, m_dif_ovf);
        chk("prod_out", bus.prod_out, m_prod);
        chk("prod_valid", bus.prod_valid, m_prod_vld);
        chk("prod_ovf", bus.prod_ovf, m_prod_ovf);
        chk("div_out", bus.div_out, m_div);
        chk("div_valid", bus.div_valid, m_div_vld);
        chk("div_err", bus.div_err, m_div_err);
        chk("div_busy", bus.div_busy, m_busy);
    endtask

    task automatic apply(input logic r, input logic v, input logic signed [W-1:0] a,
                         input logic signed [W-1:0] b);
        rst = r;
        bus.valid_in = v;
        bus.n1 = a;
        bus.n2 = b;
        @(posedge clk);
        model_edge(r, v, a, b);
        @(negedge clk);
        check_all();
    endtask

    task automatic op(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        apply(0, 1, a, b);
        for (int i = 0; i < W + 4 && m_busy; i++) apply(0, 0, a, b);
    endtask

    function automatic logic signed [W-1:0] rnd_op();
        logic signed [W-1:0] x;
        case ($urandom_range(0, 5))
            0: x = '0;
            1: x = -1;
            2: x = lo(LMIN);
            3: x = lo(LMAX);
            4: x = W'($signed($urandom_range(0, 400)) - 200);
            default: x = W'($urandom);
        endcase
        return x;
    endfunction

    initial begin
        int div_pulses;
        apply(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        chk("rst_dif", bus.dif_out, W'(0));
        chk("rst_busy", bus.div_busy, 1'b0);

        // Three back-to-back requests: one result per cycle, only the first reaches the divider.
        apply(0, 1, 412, 3534);
        chk("dif_412", bus.dif_out, W'(-3122));
        chk("prod_412", bus.prod_out, W'(1456008));
        apply(0, 1, 412, 3534);
        apply(0, 1, 412, 3534);
        div_pulses = 0;
        for (int i = 0; i < W + 4 && m_busy; i++) begin
            apply(0, 0, 412, 3534);
            if (bus.div_valid) div_pulses++;
        end
        chk("div_412_pulses", div_pulses, 1);
        chk("div_412", bus.div_out, W'(0));

        op(99999900, 120);
        chk("dif_999", bus.dif_out, W'(99999780));
        chk("prod_ovf_999", bus.prod_ovf, 1'b1);
        chk("div_999", bus.div_out, W'(833332));

        apply(0, 1, -2556, 0);
        chk("div0_valid", bus.div_valid, 1'b1);
        chk("div0_err", bus.div_err, 1'b1);
        chk("div0_out", bus.div_out, W'(0));
        apply(0, 0, 0, 0);
        chk("dif_2556", bus.dif_out, W'(-2556));

        op(-96091078, -5346);
        chk("dif_960", bus.dif_out, W'(-96085732));
        chk("div_960", bus.div_out, W'(17974));
        op(169, 13);
        chk("div_169", bus.div_out, W'(13));
        chk("prod_169", bus.prod_out, W'(2197));
        op(168, 13);
        chk("div_168", bus.div_out, W'(12));
        chk("prod_168", bus.prod_out, W'(2184));

        op(134217727, -1);
        chk("dif_ovf_max", bus.dif_ovf, 1'b1);
`ifdef OVF_SAT_EN
        chk("dif_sat_max", bus.dif_out, W'(134217727));
`else
        chk("dif_wrap_max", bus.dif_out, W'(-134217728));
`endif
        op(lo(LMIN), -1);
        chk("div_min_err", bus.div_err, 1'b1);

        // Abort a division mid-run; no pulse may follow.
        apply(0, 1, 5000, 7);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0);
        apply(1, 0, 0, 0);
        chk("abort_busy", bus.div_busy, 1'b0);
        for (int i = 0; i < W + 4; i++) apply(0, 0, 0, 0);

        // valid_in held through RUN and DONE.
        for (int i = 0; i < 2 * W + 6; i++) apply(0, 1, 1000 + i, -7);

        for (int i = 0; i < 1500; i++)
            apply($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), rnd_op(), rnd_op());

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
